// File: rtl/ex_muldiv_sequencer_pkg.sv
// Shared types and helpers for the RV32M multi-cycle mul/div sequencer.
// Op encoding follows funct3 so the decoder can pass it straight through.
package ex_muldiv_sequencer_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    function automatic logic is_div(input muldiv_op_t op);
        return op[2];
    endfunction

    function automatic logic is_rem(input muldiv_op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // MUL keeps both operands unsigned: the low word is sign-agnostic.
    function automatic logic op_signed_a(input muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_signed_b(input muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_sequencer_step.sv
// One radix-2 iteration: shift-add for multiply, subtract-compare-restore for divide.
// Accumulator layout: multiply {hi, multiplier}; divide {remainder, dividend/quotient}.
module ex_muldiv_sequencer_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic              div_mode,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   mcand,
    output logic [2*XLEN-1:0] acc_out
);
    logic [XLEN:0]   sum;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] diff;
    logic            fits;

    always_comb begin
        sum   = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, mcand} : '0);
        trial = acc_in[2*XLEN-1:XLEN-1];
        fits  = trial >= {1'b0, mcand};
        // Remainder stays below the divisor, so the true difference fits in XLEN bits.
        diff  = trial[XLEN-1:0] - mcand;
        if (!div_mode) begin
            acc_out = {sum, acc_in[XLEN-1:1]};
        end else if (fits) begin
            acc_out = {diff, acc_in[XLEN-2:0], 1'b1};
        end else begin
            acc_out = {trial[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// EX-stage RV32M sequencer: captures operand magnitudes, iterates XLEN steps while stalling
// the front end, then presents a one-cycle registered result in DONE.
module ex_muldiv_sequencer
    import ex_muldiv_sequencer_pkg::*;
#(
    parameter int unsigned XLEN         = XLEN_DEFAULT,
    parameter bit          FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            stall_out,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);
    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2*XLEN-1:0] acc_q, acc_d, step_acc;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   result_q, result_d;
    muldiv_op_t        op_q, op_d;
    logic              neg_q, neg_d;
    logic              special_q, special_d;

    muldiv_op_t        op_in;
    logic              sign_a, sign_b, neg_in, div_zero, div_ovf, special;
    logic [XLEN-1:0]   abs_a, abs_b, special_val, fixed_result, quot, rem;
    logic [2*XLEN-1:0] prod;

    always_comb begin
        op_in    = muldiv_op_t'(op);
        sign_a   = op_signed_a(op_in) & operand_a[XLEN-1];
        sign_b   = op_signed_b(op_in) & operand_b[XLEN-1];
        abs_a    = sign_a ? -operand_a : operand_a;
        abs_b    = sign_b ? -operand_b : operand_b;
        // Remainder takes the dividend's sign; everything else the XOR of both.
        neg_in   = (op_in == OP_REM) ? sign_a : (sign_a ^ sign_b);
        div_zero = is_div(op_in) && (operand_b == '0);
        div_ovf  = is_div(op_in) && op_signed_b(op_in) && (operand_a == MIN_INT)
                   && (operand_b == '1);
        special  = div_zero || div_ovf;
        if (div_zero) begin
            special_val = is_rem(op_in) ? operand_a : '1;
        end else begin
            special_val = is_rem(op_in) ? '0 : operand_a;
        end
    end

    ex_muldiv_sequencer_step #(
        .XLEN(XLEN)
    ) u_step (
        .div_mode(is_div(op_q)),
        .acc_in  (acc_q),
        .mcand   (mcand_q),
        .acc_out (step_acc)
    );

    always_comb begin
        prod = neg_q ? -step_acc : step_acc;
        quot = neg_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
        rem  = neg_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
        if (!is_div(op_q)) begin
            fixed_result = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else begin
            fixed_result = is_rem(op_q) ? rem : quot;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        result_d  = result_q;
        op_d      = op_q;
        neg_d     = neg_q;
        special_d = special_q;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    count_d   = '0;
                    op_d      = op_in;
                    neg_d     = neg_in;
                    special_d = special;
                    result_d  = special_val;
                    if (is_div(op_in)) begin
                        acc_d   = {{XLEN{1'b0}}, abs_a};
                        mcand_d = abs_b;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, abs_b};
                        mcand_d = abs_a;
                    end
                    state_d = (special && FAST_SPECIAL) ? DONE : BUSY;
                end
            end
            BUSY: begin
                acc_d   = step_acc;
                count_d = count_q + CW'(1);
                if (count_q == CW'(XLEN - 1)) begin
                    state_d  = DONE;
                    result_d = special_q ? result_q : fixed_result;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            result_q  <= '0;
            op_q      <= OP_MUL;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            result_q  <= result_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            special_q <= special_d;
        end
    end

    assign stall_out    = ((state_q == IDLE) && start && !flush) || (state_q == BUSY);
    assign busy         = state_q != IDLE;
    assign result_valid = state_q == DONE;
    // result_q may hold a pre-loaded special value while BUSY; only DONE exposes it.
    assign result       = result_valid ? result_q : '0;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Self-checking bench for ex_muldiv_sequencer: directed table, random ops against an
// arithmetic reference model, and hand-written flush/reset/back-to-back sequences.
module tb_ex_muldiv_sequencer;
    import ex_muldiv_sequencer_pkg::*;

    logic        clk, reset, start, flush;
    logic [2:0]  op;
    logic [31:0] operand_a, operand_b;
    logic        stall_out, busy, result_valid;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    ex_muldiv_sequencer #(
        .XLEN        (32),
        .FAST_SPECIAL(1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .flush       (flush),
        .stall_out   (stall_out),
        .busy        (busy),
        .result_valid(result_valid),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic is_special(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
        if (o < 3'd4) return 1'b0;
        if (b == 32'd0) return 1'b1;
        return (o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          ia, ib, iq;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (o)
            3'd0: begin p = 64'(ua * ub); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (is_special(o, a, b)) return a;
                iq = ia / ib;
                return iq;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (is_special(o, a, b)) return 32'd0;
                iq = ia % ib;
                return iq;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issue one op with start held until DONE, then check value, latency and stall length.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
        int lat, stalls, exp_lat;
        exp_lat = is_special(o, a, b) ? 1 : 33;
        @(negedge clk);
        start = 1'b1;
        op = o;
        operand_a = a;
        operand_b = b;
        #1;
        lat = 0;
        stalls = 0;
        while (!result_valid && lat < 100) begin
            if (stall_out) stalls++;
            @(negedge clk);
            lat++;
        end
        chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({name, "_res"}, result, exp);
        chk({name, "_stalls"}, 32'(stalls), 32'(exp_lat));
        chk({name, "_done_stall"}, {31'd0, stall_out}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        chk({name, "_idle"}, {30'd0, busy, result_valid}, 32'd0);
    endtask

    initial begin
        int n;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3"};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max"};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1_m1"};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, "mulhsu_m1_2"};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div_m7_2"};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem_m7_2"};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        "divu_100_7"};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         "remu_100_7"};
        vecs[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, "div_by_0"};
        vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         "rem_by_0"};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         "rem_ovf"};

        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op = 3'd0;
        operand_a = 32'd0;
        operand_b = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0: ra = 32'd0;
                1: ra = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: ra = $urandom_range(0, 20);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'h8000_0000;
                3: rb = $urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, model(ro, ra, rb), $sformatf("rnd%0d_op%0d", i, ro));
        end

        // Flush at BUSY cycle 10: op dies, nothing retires.
        @(negedge clk);
        start = 1'b1;
        op = 3'd0;
        operand_a = 32'd123;
        operand_b = 32'd456;
        repeat (11) @(negedge clk);
        chk("flush_pre_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        start = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle", {30'd0, busy, stall_out}, 32'd0);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (result_valid) n++;
        end
        chk("flush_no_result", 32'(n), 32'd0);
        run_op(3'd0, 32'd123, 32'd456, 32'd56088, "after_flush");

        // Flush and start together in IDLE: no accept.
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        op = 3'd5;
        operand_a = 32'd9;
        operand_b = 32'd3;
        #1;
        chk("flush_start_stall", {31'd0, stall_out}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start_busy", {31'd0, busy}, 32'd0);

        // Async reset between edges mid-BUSY.
        @(negedge clk);
        start = 1'b1;
        op = 3'd4;
        operand_a = 32'd1000;
        operand_b = 32'd3;
        repeat (6) @(negedge clk);
        #2;
        start = 1'b0;
        reset = 1'b1;
        #1;
        chk("areset_outputs", {29'd0, busy, stall_out, result_valid}, 32'd0);
        chk("areset_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(3'd4, 32'd1000, 32'd3, 32'd333, "after_reset");

        // Back-to-back DIVs with start held through DONE.
        @(negedge clk);
        start = 1'b1;
        op = 3'd4;
        operand_a = 32'd100;
        operand_b = 32'd7;
        n = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (result_valid) begin
                n++;
                if (n == 1) begin
                    chk("b2b_first", result, 32'd14);
                    operand_a = 32'hFFFF_FFF9;
                    operand_b = 32'd2;
                end else if (n == 2) begin
                    chk("b2b_second", result, 32'hFFFF_FFFD);
                    start = 1'b0;
                end
            end
        end
        chk("b2b_count", 32'(n), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
